framebuffer_scanout: RTL and testbench



---
 rtl/framebuffer_scanout_if.sv | 12 +
 rtl/framebuffer_scanout.sv | 148 ++++++++++++++
 tb/tb_framebuffer_scanout.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_scanout_if.sv
// BRAM read port between the scanout engine and the framebuffer memory.
// The scanout side drives the {buffer, pixel} address and consumes the data word.
interface framebuffer_scanout_if #(
  parameter int PIX_ADDR_BITS      = 18,
  parameter int PADDED_COLOR_WIDTH = 16
);
  logic [PIX_ADDR_BITS:0]          bram_addr;
  logic [PADDED_COLOR_WIDTH-1:0]   bram_dout;

  modport master (output bram_addr, input bram_dout);
  modport slave  (input bram_addr, output bram_dout);
endinterface

// File: rtl/framebuffer_scanout.sv
// Framebuffer read side: upscaled VGA scanout from the displayed buffer with
// sync/blank aligned to BRAM latency, plus the frame-boundary buffer-swap handshake.
module framebuffer_scanout #(
  parameter int FRAME_WIDTH        = 512,
  parameter int FRAME_HEIGHT       = 384,
  parameter int SCALE_SHIFT        = 1,
  parameter int COORD_BITS         = 16,
  parameter int PIX_ADDR_BITS      = 18,
  parameter int BRAM_LATENCY       = 2,
  parameter int COLOR_WIDTH        = 12,
  parameter int PADDED_COLOR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [COORD_BITS-1:0] hcount_in,
  input  logic [COORD_BITS-1:0] vcount_in,
  input  logic                  hsync_in,
  input  logic                  vsync_in,
  input  logic                  blank_in,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  read_buffer,
  output logic                  frame_start,
  output logic [3:0]            vga_r,
  output logic [3:0]            vga_g,
  output logic [3:0]            vga_b,
  output logic                  vga_hs,
  output logic                  vga_vs,
  framebuffer_scanout_if.master bram
);

  localparam int PIPE_LEN = 2 + BRAM_LATENCY;
  localparam int DLY      = PIPE_LEN - 1;
  localparam logic [COORD_BITS-1:0] FW_C = COORD_BITS'(FRAME_WIDTH);
  localparam logic [COORD_BITS-1:0] FH_C = COORD_BITS'(FRAME_HEIGHT);

  typedef enum logic {IDLE, PENDING} swap_state_t;

  swap_state_t              state_reg;
  logic                     read_buffer_reg;
  logic                     vsync_q_reg;
  logic                     vsync_armed_reg;
  logic                     vsync_edge;
  logic [PIX_ADDR_BITS:0]   addr_reg;
  logic [COORD_BITS-1:0]    x_src;
  logic [COORD_BITS-1:0]    y_src;
  logic [PIX_ADDR_BITS-1:0] pix_idx;
  logic                     in_range;
  logic [2:0]               tap_in;
  logic [2:0]               tap_out;
  logic [3:0]               vga_r_reg, vga_g_reg, vga_b_reg;
  logic                     vga_hs_reg, vga_vs_reg;
  logic                     unused_dout_bits;

  assign x_src    = hcount_in >> SCALE_SHIFT;
  assign y_src    = vcount_in >> SCALE_SHIFT;
  assign in_range = (x_src < FW_C) && (y_src < FH_C) && !blank_in;
  assign pix_idx  = PIX_ADDR_BITS'(y_src) * PIX_ADDR_BITS'(FRAME_WIDTH) + PIX_ADDR_BITS'(x_src);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_reg <= '0;
    end else begin
      addr_reg <= {read_buffer_reg, in_range ? pix_idx : '0};
    end
  end

  assign bram.bram_addr = addr_reg;

  // Delay line carries {in_range, vsync, hsync}; the final stage is the output register.
  assign tap_in = {in_range, vsync_in, hsync_in};

  genvar gi;
  generate
    for (gi = 0; gi < DLY; gi++) begin : g_dly
      logic [2:0] stage_reg;
      if (gi == 0) begin : g_head
        always_ff @(posedge clk) begin
          if (!rst_n) stage_reg <= '0;
          else        stage_reg <= tap_in;
        end
      end else begin : g_tail
        always_ff @(posedge clk) begin
          if (!rst_n) stage_reg <= '0;
          else        stage_reg <= g_dly[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  assign tap_out = g_dly[DLY-1].stage_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vga_r_reg  <= '0;
      vga_g_reg  <= '0;
      vga_b_reg  <= '0;
      vga_hs_reg <= 1'b1;
      vga_vs_reg <= 1'b1;
    end else begin
      vga_r_reg  <= tap_out[2] ? bram.bram_dout[COLOR_WIDTH-1 -: 4] : 4'd0;
      vga_g_reg  <= tap_out[2] ? bram.bram_dout[COLOR_WIDTH-5 -: 4] : 4'd0;
      vga_b_reg  <= tap_out[2] ? bram.bram_dout[3:0]                : 4'd0;
      vga_hs_reg <= ~tap_out[0];
      vga_vs_reg <= ~tap_out[1];
    end
  end

  assign unused_dout_bits = ^bram.bram_dout[PADDED_COLOR_WIDTH-1:COLOR_WIDTH];

  assign vga_r  = vga_r_reg;
  assign vga_g  = vga_g_reg;
  assign vga_b  = vga_b_reg;
  assign vga_hs = vga_hs_reg;
  assign vga_vs = vga_vs_reg;

  // Edges only count once vsync has been seen low after reset, so a vsync
  // already high at reset release does not look like a new frame.
  assign vsync_edge  = vsync_in & ~vsync_q_reg & vsync_armed_reg;
  assign frame_start = vsync_edge;
  assign swap_ack    = (state_reg == PENDING) & vsync_edge;
  assign read_buffer = read_buffer_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      read_buffer_reg <= 1'b0;
      vsync_q_reg     <= 1'b0;
      vsync_armed_reg <= 1'b0;
    end else begin
      vsync_q_reg <= vsync_in;
      if (!vsync_in) vsync_armed_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (swap_req) state_reg <= PENDING;
        end
        PENDING: begin
          if (vsync_edge) begin
            read_buffer_reg <= ~read_buffer_reg;
            state_reg       <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed vectors plus a randomized run against a frame-level reference model
// for the framebuffer scanout block.
module tb_framebuffer_scanout;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, blank_in, swap_req;
  logic        swap_ack, read_buffer, frame_start;
  logic [3:0]  vga_r, vga_g, vga_b;
  logic        vga_hs, vga_vs;

  logic        ovr_en;
  logic [15:0] ovr_val;
  logic [15:0] d1_reg, d2_reg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  framebuffer_scanout_if bus ();

  framebuffer_scanout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .hcount_in   (hcount_in),
    .vcount_in   (vcount_in),
    .hsync_in    (hsync_in),
    .vsync_in    (vsync_in),
    .blank_in    (blank_in),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .read_buffer (read_buffer),
    .frame_start (frame_start),
    .vga_r       (vga_r),
    .vga_g       (vga_g),
    .vga_b       (vga_b),
    .vga_hs      (vga_hs),
    .vga_vs      (vga_vs),
    .bram        (bus)
  );

  function automatic logic [15:0] mem_word(input logic [18:0] a);
    logic [31:0] h;
    h = {13'd0, a} * 32'h9E3779B1;
    return h[31:16] ^ {13'd0, a[2:0]};
  endfunction

  // Two-cycle BRAM model, overridable with a fixed word for directed vectors.
  always @(posedge clk) begin
    d1_reg <= mem_word(bus.bram_addr);
    d2_reg <= d1_reg;
  end
  assign bus.bram_dout = ovr_en ? ovr_val : d2_reg;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [15:0] hc, vc;
    logic        blank;
    logic [15:0] dout;
    logic [18:0] addr;
    logic [11:0] rgb;
  } vec_t;

  typedef struct {
    logic [18:0] addr;
    logic [11:0] rgb;
    logic        hs, vs;
  } hist_t;

  vec_t  vecs[8];
  hist_t hist[$];

  initial begin
    logic        m_rb, m_pend, m_armed, m_vsp, m_edge;
    logic [18:0] e_addr;
    logic [15:0] w;
    hist_t       h;
    int          x, y;
    logic        inr;

    vecs[0] = '{16'd10,   16'd6,   1'b0, 16'hFABC, 19'd1541,   12'hABC};
    vecs[1] = '{16'd10,   16'd6,   1'b1, 16'h0FFF, 19'd0,      12'h000};
    vecs[2] = '{16'd1030, 16'd6,   1'b0, 16'h0FFF, 19'd0,      12'h000};
    vecs[3] = '{16'd1023, 16'd767, 1'b0, 16'h1234, 19'd196607, 12'h234};
    vecs[4] = '{16'd0,    16'd0,   1'b0, 16'h0ABC, 19'd0,      12'hABC};
    vecs[5] = '{16'd0,    16'd768, 1'b0, 16'h0FFF, 19'd0,      12'h000};
    vecs[6] = '{16'd1024, 16'd0,   1'b0, 16'h0FFF, 19'd0,      12'h000};
    vecs[7] = '{16'd3,    16'd5,   1'b0, 16'h8F21, 19'd1025,   12'hF21};

    rst_n = 1'b0; hcount_in = '0; vcount_in = '0; hsync_in = 1'b1; vsync_in = 1'b1;
    blank_in = 1'b1; swap_req = 1'b0; ovr_en = 1'b0; ovr_val = '0;

    // Reset with syncs asserted
    repeat (5) tick();
    chk("rst_rgb", {vga_r, vga_g, vga_b}, 0);
    chk("rst_hs", vga_hs, 1);
    chk("rst_vs", vga_vs, 1);
    chk("rst_rb", read_buffer, 0);
    chk("rst_ack", swap_ack, 0);
    chk("rst_addr", bus.bram_addr, 0);
    chk("rst_fs", frame_start, 0);
    rst_n = 1'b1;
    #1;
    chk("rel_fs0", frame_start, 0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("rel_fs_hold", frame_start, 0);
    end
    vsync_in = 1'b0;
    tick(); tick();
    vsync_in = 1'b1;
    #1;
    chk("first_edge_fs", frame_start, 1);
    tick();
    chk("first_edge_fs_end", frame_start, 0);

    // Table-driven address / colour / range vectors
    hsync_in = 1'b0;
    ovr_en   = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hcount_in = vecs[i].hc; vcount_in = vecs[i].vc;
      blank_in  = vecs[i].blank; ovr_val = vecs[i].dout;
      tick();
      chk($sformatf("vec%0d_addr", i), bus.bram_addr, vecs[i].addr);
      tick(); tick(); tick();
      chk($sformatf("vec%0d_rgb", i), {vga_r, vga_g, vga_b}, vecs[i].rgb);
    end
    ovr_en = 1'b0;

    // hsync pulse of 3 cycles appears 4 cycles later with the same width
    hsync_in = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("hs_align_k%0d", k), vga_hs, (k >= 4 && k <= 6) ? 0 : 1);
      if (k == 3) hsync_in = 1'b0;
    end
    chk("vs_held", vga_vs, 0);

    // Mid-frame swap request waits for the vsync edge
    vsync_in = 1'b0;
    tick(); tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("swap_wait_rb", read_buffer, 0);
      chk("swap_wait_ack", swap_ack, 0);
    end
    vsync_in = 1'b1;
    #1;
    chk("swap_edge_ack", swap_ack, 1);
    chk("swap_edge_rb", read_buffer, 0);
    tick();
    chk("swap_after_rb", read_buffer, 1);
    chk("swap_after_ack", swap_ack, 0);
    hcount_in = 16'd10; vcount_in = 16'd6; blank_in = 1'b0;
    tick();
    chk("swap_addr", bus.bram_addr, 263685);

    // Request coincident with the edge is deferred to the following edge
    vsync_in = 1'b0;
    tick(); tick();
    vsync_in = 1'b1; swap_req = 1'b1;
    #1;
    chk("coinc_fs", frame_start, 1);
    chk("coinc_ack", swap_ack, 0);
    tick();
    swap_req = 1'b0;
    chk("coinc_rb", read_buffer, 1);
    vsync_in = 1'b0;
    tick(); tick();
    vsync_in = 1'b1;
    #1;
    chk("coinc_next_ack", swap_ack, 1);
    tick();
    chk("coinc_next_rb", read_buffer, 0);

    // Three requests in one frame yield exactly one swap
    vsync_in = 1'b0;
    for (int p = 0; p < 3; p++) begin
      tick(); swap_req = 1'b1;
      tick(); swap_req = 1'b0;
    end
    tick();
    vsync_in = 1'b1;
    #1;
    chk("dup_ack", swap_ack, 1);
    tick();
    chk("dup_rb", read_buffer, 1);
    vsync_in = 1'b0;
    tick(); tick();
    vsync_in = 1'b1;
    #1;
    chk("dup_fs2", frame_start, 1);
    chk("dup_ack2", swap_ack, 0);
    tick();
    chk("dup_rb2", read_buffer, 1);

    // Reset while a swap is pending discards it
    vsync_in = 1'b0; swap_req = 1'b1;
    tick();
    swap_req = 1'b0; rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rstpend_rb", read_buffer, 0);
    tick(); tick();
    vsync_in = 1'b1;
    #1;
    chk("rstpend_fs", frame_start, 1);
    chk("rstpend_ack", swap_ack, 0);
    tick();
    chk("rstpend_rb_after", read_buffer, 0);

    // Randomized run against the reference model
    rst_n = 1'b0;
    repeat (3) tick();
    m_rb = 1'b0; m_pend = 1'b0; m_armed = 1'b0; m_vsp = 1'b0;
    hist.delete();
    for (int n = 0; n < 3000; n++) begin
      if (n > 0) tick();
      if (hist.size() >= 1) chk("rnd_addr", bus.bram_addr, hist[$].addr);
      if (hist.size() >= 4) begin
        h = hist[$-3];
        chk("rnd_rgb", {vga_r, vga_g, vga_b}, h.rgb);
        chk("rnd_hs", vga_hs, !h.hs);
        chk("rnd_vs", vga_vs, !h.vs);
      end
      chk("rnd_rb", read_buffer, m_rb);

      rst_n     = 1'b1;
      hcount_in = 16'($urandom_range(0, 1100));
      vcount_in = 16'($urandom_range(0, 800));
      blank_in  = ($urandom_range(0, 3) == 0);
      hsync_in  = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 19) == 0) vsync_in = ~vsync_in;
      swap_req  = ($urandom_range(0, 7) == 0);
      #1;

      m_edge = vsync_in && !m_vsp && m_armed;
      chk("rnd_fs", frame_start, m_edge);
      chk("rnd_ack", swap_ack, m_edge && m_pend);

      x   = int'(hcount_in) / 2;
      y   = int'(vcount_in) / 2;
      inr = (x < 512) && (y < 384) && !blank_in;
      e_addr = {m_rb, inr ? 18'(y * 512 + x) : 18'd0};
      w = mem_word(e_addr);
      h.addr = e_addr;
      h.rgb  = inr ? w[11:0] : 12'd0;
      h.hs   = hsync_in;
      h.vs   = vsync_in;
      hist.push_back(h);
      if (hist.size() > 4) void'(hist.pop_front());

      if (m_pend && m_edge) begin
        m_rb   = !m_rb;
        m_pend = 1'b0;
      end else if (!m_pend && swap_req) begin
        m_pend = 1'b1;
      end
      if (!vsync_in) m_armed = 1'b1;
      m_vsp = vsync_in;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
